// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU datapath between two requesters. A round-robin grant picks
// one requester per cycle; the chosen operation is computed combinationally
// and captured into a single-entry result register (one-cycle latency, one
// operation per cycle when the consumer keeps up).
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_valid / req0_ready    requester 0 handshake (ready is combinational)
//   req0_srca, req0_srcb       requester 0 signed operands
//   req0_op                    requester 0 operation code
//   req1_*                     same set for requester 1
//   resp_valid / resp_ready    result handshake
//   resp_result                registered signed result
//   resp_src                   index of the requester that produced the result
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_srca,
    input  logic [DATA_WIDTH-1:0]    req0_srcb,
    input  logic [OPCODE_LENGTH-1:0] req0_op,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_srca,
    input  logic [DATA_WIDTH-1:0]    req1_srcb,
    input  logic [OPCODE_LENGTH-1:0] req1_op,

    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [DATA_WIDTH-1:0]    resp_result,
    output logic                     resp_src
);

    // Shift-amount width for SRL/SRA (B[4:0] at the default 32-bit width).
    localparam int unsigned SHW = $clog2(DATA_WIDTH);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR  = OPCODE_LENGTH'(4'b0001);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0010);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB = OPCODE_LENGTH'(4'b0101);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b1100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRL = OPCODE_LENGTH'(4'b1101);
    localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b1110);

    logic                     last_grant;
    logic                     slot_free;
    logic                     grant0;
    logic                     grant1;
    logic                     accept;
    logic [DATA_WIDTH-1:0]    sel_a;
    logic [DATA_WIDTH-1:0]    sel_b;
    logic [OPCODE_LENGTH-1:0] sel_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    // Round-robin grant: contention goes to the requester that did not win last.
    always_comb begin
        slot_free  = !resp_valid || resp_ready;
        grant0     = req0_valid && (!req1_valid || last_grant);
        grant1     = req1_valid && !grant0;
        // rst_n gating keeps both readys low for the whole reset period.
        req0_ready = rst_n && slot_free && grant0;
        req1_ready = rst_n && slot_free && grant1;
        accept     = req0_ready || req1_ready;
    end

    // Operand steering; the non-granted requester never reaches the ALU.
    always_comb begin
        sel_a  = req0_srca;
        sel_b  = req0_srcb;
        sel_op = req0_op;
        if (grant1) begin
            sel_a  = req1_srca;
            sel_b  = req1_srcb;
            sel_op = req1_op;
        end
    end

    // Shared ALU; unknown opcodes yield zero.
    always_comb begin
        alu_result = '0;
        case (sel_op)
            OP_AND: alu_result = sel_a & sel_b;
            OP_OR:  alu_result = sel_a | sel_b;
            OP_XOR: alu_result = sel_a ^ sel_b;
            OP_ADD: alu_result = sel_a + sel_b;
            OP_SUB: alu_result = sel_a - sel_b;
            OP_EQ:  alu_result = DATA_WIDTH'(sel_a == sel_b);
            // Left shift uses the full unsigned B, so any B >= width clears.
            OP_SLL: alu_result = (sel_b >= DATA_WIDTH'(DATA_WIDTH)) ? '0 : (sel_a << sel_b);
            OP_SRL: alu_result = sel_a >> sel_b[SHW-1:0];
            OP_SRA: alu_result = DATA_WIDTH'($signed(sel_a) >>> sel_b[SHW-1:0]);
            default: alu_result = '0;
        endcase
    end

    // Result stage: load on accept, drain on consume, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_src    <= 1'b0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_result <= alu_result;
            resp_src    <= grant1;
            last_grant  <= grant1;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule
